// File: rtl/cosim_commit_serializer.sv
// Commit-bundle serializer between the ROB and the Dromajo co-sim checker.
// Optional counters are enabled with `define COSIM_SERIALIZER_STATS_EN.
module cosim_commit_serializer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int DEPTH        = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [31:0]                  in_hartid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_int_xcpt,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_hartid,
  output logic [XLEN-1:0]              out_pc,
  output logic [31:0]                  out_inst,
  output logic [XLEN-1:0]              out_wdata,
  output logic [XLEN-1:0]              out_mstatus,
  output logic                         out_check,
  output logic                         out_trap_valid,
  output logic [XLEN-1:0]              out_cause,
`ifdef COSIM_SERIALIZER_STATS_EN
  output logic                         overflow,
  output logic [63:0]                  stat_commits,
  output logic [31:0]                  stat_traps,
  output logic [63:0]                  stat_stall_cycles
`else
  output logic                         overflow
`endif
);

  localparam int CW = COMMIT_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = (CW > 1) ? $clog2(CW) : 1;

  typedef struct packed {
    logic [CW-1:0]      vld;
    logic [31:0]        hartid;
    logic [CW*XLEN-1:0] pc;
    logic [CW*32-1:0]   inst;
    logic [CW*XLEN-1:0] wdata;
    logic [CW*XLEN-1:0] mstatus;
    logic [CW-1:0]      chk;
    logic               trap;
    logic [XLEN-1:0]    cause;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LANE,
    TRAP
  } state_e;

  // {found, index} of the lowest set bit of v at or above from
  function automatic logic [LW:0] first_from(
    input logic [CW-1:0] v,
    input int            from
  );
    logic [LW:0] r;
    r = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      if (v[i] && i >= from) r = {1'b1, LW'(i)};
    end
    return r;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          head_q, head_d;
  entry_t          in_e, src_e;
  state_e          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [AW-1:0]   rd_idx;
  logic [AW:0]     rem;
  logic            in_ready_q, in_ready_d;
  logic            ovf_q, ovf_d;
  logic            enq_req, enq, pop, full;
  logic            want_load;
  logic [LW:0]     nxt, first;

  always_comb begin
    in_e         = '0;
    in_e.vld     = in_valid;
    in_e.hartid  = in_hartid;
    in_e.pc      = in_pc;
    in_e.inst    = in_inst;
    in_e.wdata   = in_wdata;
    in_e.mstatus = in_mstatus;
    in_e.chk     = in_check;
    in_e.trap    = in_int_xcpt;
    in_e.cause   = in_cause;
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    head_d    = head_q;
    pop       = 1'b0;
    want_load = 1'b0;
    first     = '0;
    nxt       = first_from(head_q.vld, int'(lane_q) + 1);

    unique case (state_q)
      IDLE: want_load = 1'b1;
      LANE: begin
        if (out_ready) begin
          if (nxt[LW]) begin
            lane_d = nxt[LW-1:0];
          end else if (head_q.trap) begin
            state_d = TRAP;
          end else begin
            pop       = 1'b1;
            want_load = 1'b1;
          end
        end
      end
      TRAP: begin
        if (out_ready) begin
          pop       = 1'b1;
          want_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    enq_req = (|in_valid) | in_int_xcpt;
    full    = (count_q == (AW+1)'(DEPTH));
    // A pop in the same cycle frees the slot for a full-FIFO enqueue
    enq     = enq_req && (!full || pop);
    ovf_d   = ovf_q | (enq_req && full && !pop);

    rem    = count_q - (AW+1)'(pop);
    rd_idx = rptr_q + AW'(pop);
    src_e  = (rem != '0) ? mem_q[rd_idx] : in_e;

    // Empty FIFO with an enqueue bypasses the input into the head
    if (want_load) begin
      if (rem != '0 || enq) begin
        head_d  = src_e;
        first   = first_from(src_e.vld, 0);
        lane_d  = first[LW-1:0];
        state_d = first[LW] ? LANE : TRAP;
      end else begin
        state_d = IDLE;
      end
    end

    count_d    = count_q + (AW+1)'(enq) - (AW+1)'(pop);
    in_ready_d = (count_d != (AW+1)'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (enq) mem_q[wptr_q] <= in_e;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      head_q     <= '0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      in_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      head_q     <= head_d;
      count_q    <= count_d;
      rptr_q     <= rptr_q + AW'(pop);
      wptr_q     <= wptr_q + AW'(enq);
      in_ready_q <= in_ready_d;
      ovf_q      <= ovf_d;
    end
  end

  logic [XLEN-1:0] lane_pc, lane_wdata, lane_mstatus;
  logic [31:0]     lane_inst;

  always_comb begin
    lane_pc      = head_q.pc[int'(lane_q)*XLEN +: XLEN];
    lane_wdata   = head_q.wdata[int'(lane_q)*XLEN +: XLEN];
    lane_mstatus = head_q.mstatus[int'(lane_q)*XLEN +: XLEN];
    lane_inst    = head_q.inst[int'(lane_q)*32 +: 32];
  end

  assign in_ready       = in_ready_q;
  assign overflow       = ovf_q;
  assign out_valid      = (state_q == LANE);
  assign out_trap_valid = (state_q == TRAP);
  assign out_pc         = out_valid ? lane_pc : '0;
  assign out_inst       = out_valid ? lane_inst : '0;
  assign out_wdata      = out_valid ? lane_wdata : '0;
  assign out_mstatus    = out_valid ? lane_mstatus : '0;
  assign out_check      = out_valid & head_q.chk[lane_q];
  assign out_cause      = out_trap_valid ? head_q.cause : '0;
  assign out_hartid     = (out_valid | out_trap_valid) ? head_q.hartid : '0;

`ifdef COSIM_SERIALIZER_STATS_EN
  logic [63:0] commits_q, stalls_q;
  logic [31:0] traps_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commits_q <= '0;
      traps_q   <= '0;
      stalls_q  <= '0;
    end else begin
      if (out_valid && out_ready && commits_q != '1)
        commits_q <= commits_q + 64'd1;
      if (out_trap_valid && out_ready && traps_q != '1)
        traps_q <= traps_q + 32'd1;
      if (!in_ready_q && enq_req && stalls_q != '1)
        stalls_q <= stalls_q + 64'd1;
    end
  end

  assign stat_commits      = commits_q;
  assign stat_traps        = traps_q;
  assign stat_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_cosim_commit_serializer.sv
// Directed bench for cosim_commit_serializer: vector table plus
// backpressure, back-to-back and mid-drain reset sequences.
module tb_cosim_commit_serializer;

  localparam int CW    = 2;
  localparam int XLEN  = 64;
  localparam int DEPTH = 8;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [CW-1:0]        in_valid;
  logic [31:0]          in_hartid;
  logic [XLEN*CW-1:0]   in_pc;
  logic [32*CW-1:0]     in_inst;
  logic [XLEN*CW-1:0]   in_wdata;
  logic [XLEN*CW-1:0]   in_mstatus;
  logic [CW-1:0]        in_check;
  logic                 in_int_xcpt;
  logic [XLEN-1:0]      in_cause;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_hartid;
  logic [XLEN-1:0]      out_pc;
  logic [31:0]          out_inst;
  logic [XLEN-1:0]      out_wdata;
  logic [XLEN-1:0]      out_mstatus;
  logic                 out_check;
  logic                 out_trap_valid;
  logic [XLEN-1:0]      out_cause;
  logic                 overflow;
`ifdef COSIM_SERIALIZER_STATS_EN
  logic [63:0]          stat_commits;
  logic [31:0]          stat_traps;
  logic [63:0]          stat_stall_cycles;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cosim_commit_serializer #(
    .COMMIT_WIDTH(CW),
    .XLEN(XLEN),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_hartid(in_hartid),
    .in_pc(in_pc),
    .in_inst(in_inst),
    .in_wdata(in_wdata),
    .in_mstatus(in_mstatus),
    .in_check(in_check),
    .in_int_xcpt(in_int_xcpt),
    .in_cause(in_cause),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hartid(out_hartid),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .out_wdata(out_wdata),
    .out_mstatus(out_mstatus),
    .out_check(out_check),
    .out_trap_valid(out_trap_valid),
    .out_cause(out_cause),
`ifdef COSIM_SERIALIZER_STATS_EN
    .overflow(overflow),
    .stat_commits(stat_commits),
    .stat_traps(stat_traps),
    .stat_stall_cycles(stat_stall_cycles)
`else
    .overflow(overflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  vld;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic        trap;
    logic [63:0] cause;
    logic [1:0]  k0, k1, k2;
    logic [63:0] v0, v1, v2;
  } vec_t;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_COM  = 2'd1;
  localparam logic [1:0] K_TRAP = 2'd2;

  vec_t vt [6];

  function automatic vec_t mk(
    input logic [1:0] vld, input logic [63:0] pc0, input logic [63:0] pc1,
    input logic trap, input logic [63:0] cause,
    input logic [1:0] k0, input logic [63:0] v0,
    input logic [1:0] k1, input logic [63:0] v1,
    input logic [1:0] k2, input logic [63:0] v2
  );
    vec_t v;
    v.vld = vld; v.pc0 = pc0; v.pc1 = pc1;
    v.trap = trap; v.cause = cause;
    v.k0 = k0; v.v0 = v0;
    v.k1 = k1; v.v1 = v1;
    v.k2 = k2; v.v2 = v2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane side fields are derived from the pc so the bench can predict them
  task automatic drive(input logic [1:0] vld, input logic [63:0] pc0,
                       input logic [63:0] pc1, input logic trap,
                       input logic [63:0] cause, input logic [31:0] hart);
    in_valid    = vld;
    in_hartid   = hart;
    in_pc       = {pc1, pc0};
    in_inst     = {pc1[31:0] ^ 32'h13, pc0[31:0] ^ 32'h13};
    in_wdata    = {~pc1, ~pc0};
    in_mstatus  = {pc1 ^ 64'hA, pc0 ^ 64'hA};
    in_check    = {pc1[2], pc0[2]};
    in_int_xcpt = trap;
    in_cause    = cause;
  endtask

  task automatic idle_in();
    drive(2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 32'h0);
  endtask

  task automatic check_item(input string tag, input logic [1:0] kind,
                            input logic [63:0] val, input logic [31:0] hart);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(kind == K_COM));
    chk({tag, ".out_trap_valid"}, 64'(out_trap_valid), 64'(kind == K_TRAP));
    if (kind == K_COM) begin
      chk({tag, ".pc"}, out_pc, val);
      chk({tag, ".inst"}, 64'(out_inst), 64'(val[31:0] ^ 32'h13));
      chk({tag, ".wdata"}, out_wdata, ~val);
      chk({tag, ".mstatus"}, out_mstatus, val ^ 64'hA);
      chk({tag, ".check"}, 64'(out_check), 64'(val[2]));
    end
    if (kind == K_TRAP) chk({tag, ".cause"}, out_cause, val);
    if (kind != K_NONE) chk({tag, ".hartid"}, 64'(out_hartid), 64'(hart));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_pc;

    vt[0] = mk(2'b11, 64'h80000000, 64'h80000004, 1'b0, 64'h0,
               K_COM, 64'h80000000, K_COM, 64'h80000004, K_NONE, 64'h0);
    vt[1] = mk(2'b10, 64'h0, 64'h1000, 1'b1, 64'h8000000000000007,
               K_COM, 64'h1000, K_TRAP, 64'h8000000000000007, K_NONE, 64'h0);
    vt[2] = mk(2'b00, 64'h0, 64'h0, 1'b1, 64'h3,
               K_TRAP, 64'h3, K_NONE, 64'h0, K_NONE, 64'h0);
    vt[3] = mk(2'b01, 64'h2004, 64'h0, 1'b0, 64'h0,
               K_COM, 64'h2004, K_NONE, 64'h0, K_NONE, 64'h0);
    vt[4] = mk(2'b01, 64'h3000, 64'h0, 1'b1, 64'hB,
               K_COM, 64'h3000, K_TRAP, 64'hB, K_NONE, 64'h0);
    vt[5] = mk(2'b11, 64'h5000, 64'h5004, 1'b1, 64'h2,
               K_COM, 64'h5000, K_COM, 64'h5004, K_TRAP, 64'h2);

    idle_in();
    out_ready = 1'b1;
    reset     = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_trap_valid", 64'(out_trap_valid), 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    chk("rst.out_pc", out_pc, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst.out_valid", 64'(out_valid), 64'd0);
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      drive(vt[i].vld, vt[i].pc0, vt[i].pc1, vt[i].trap, vt[i].cause,
            32'h100 + 32'(i));
      @(negedge clock);
      idle_in();
      check_item($sformatf("v%0d.s0", i), vt[i].k0, vt[i].v0, 32'h100 + 32'(i));
      @(negedge clock);
      check_item($sformatf("v%0d.s1", i), vt[i].k1, vt[i].v1, 32'h100 + 32'(i));
      @(negedge clock);
      check_item($sformatf("v%0d.s2", i), vt[i].k2, vt[i].v2, 32'h100 + 32'(i));
      @(negedge clock);
      check_item($sformatf("v%0d.s3", i), K_NONE, 64'h0, 32'h0);
    end

    // Back-to-back single-lane bundles must reload without a bubble
    drive(2'b01, 64'h6000, 64'h0, 1'b0, 64'h0, 32'h7);
    @(negedge clock);
    drive(2'b01, 64'h6100, 64'h0, 1'b0, 64'h0, 32'h8);
    check_item("b2b.0", K_COM, 64'h6000, 32'h7);
    @(negedge clock);
    idle_in();
    check_item("b2b.1", K_COM, 64'h6100, 32'h8);
    @(negedge clock);
    check_item("b2b.2", K_NONE, 64'h0, 32'h0);

    // Fill all DEPTH entries while the checker stalls
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(2'b11, 64'h4000 + 64'(16 * i), 64'h4008 + 64'(16 * i),
            1'b0, 64'h0, 32'h9);
      @(negedge clock);
      chk($sformatf("fill%0d.in_ready", i), 64'(in_ready),
          64'(i < DEPTH - 1));
    end
    chk("fill.overflow", 64'(overflow), 64'd0);
    drive(2'b11, 64'hDEAD0000, 64'hDEAD0008, 1'b0, 64'h0, 32'h9);
    @(negedge clock);
    idle_in();
    chk("push9.overflow", 64'(overflow), 64'd1);
    chk("push9.in_ready", 64'(in_ready), 64'd0);
    chk("stall.hold_pc", out_pc, 64'h4000);
    out_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      exp_pc = 64'h4000 + 64'(16 * (k / 2)) + 64'(8 * (k % 2));
      check_item($sformatf("drain%0d", k), K_COM, exp_pc, 32'h9);
      @(negedge clock);
    end
    check_item("drain.end", K_NONE, 64'h0, 32'h0);
    chk("drain.in_ready", 64'(in_ready), 64'd1);
    chk("drain.overflow_sticky", 64'(overflow), 64'd1);

    // Reset while entries are queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 64'h7000 + 64'(16 * i), 64'h7008 + 64'(16 * i),
            1'b1, 64'h5, 32'hA);
      @(negedge clock);
    end
    idle_in();
    check_item("pre_rst", K_COM, 64'h7000, 32'hA);
    reset = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.out_trap_valid", 64'(out_trap_valid), 64'd0);
    chk("midrst.out_pc", out_pc, 64'd0);
    chk("midrst.out_hartid", 64'(out_hartid), 64'd0);
    chk("midrst.overflow", 64'(overflow), 64'd0);
    @(negedge clock);
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check_item($sformatf("postrst%0d", c), K_NONE, 64'h0, 32'h0);
    end
    chk("postrst.in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cosim_commit_serializer.md
Name: cosim_commit_serializer

Overview:
- Sits between the ROB commit interface and the Dromajo co-simulation checker.
- Captures COMMIT_WIDTH-wide commit bundles and the interrupt/exception trap event into a FIFO.
- Replays them as a single-lane, strictly ordered stream: commits in lane order, then the trap.
- Backpressures the core via in_ready so that no commit is dropped when the checker side stalls.

Parameters:
- COMMIT_WIDTH, 2, commit lanes per bundle (1..4).
- XLEN, 64, data/pc width.
- DEPTH, 8, bundle FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous active-low reset (0 = in reset).
- in_valid  in  COMMIT_WIDTH  per-lane commit valid.
- in_hartid  in  32  hart id; sampled per bundle.
- in_pc  in  XLEN*COMMIT_WIDTH  lane i at bits [(i+1)*XLEN-1 -: XLEN].
- in_inst  in  32*COMMIT_WIDTH  instruction bits per lane.
- in_wdata  in  XLEN*COMMIT_WIDTH  writeback data per lane.
- in_mstatus  in  XLEN*COMMIT_WIDTH  mstatus per lane.
- in_check  in  COMMIT_WIDTH  per-lane compare enable.
- in_int_xcpt  in  1  trap event this cycle.
- in_cause  in  XLEN  trap cause.
- in_ready  out  1  FIFO can accept a bundle.
- out_valid  out  1  a commit is presented.
- out_ready  in  1  checker consumes the presented commit or trap.
- out_hartid  out  32  hart id of the presented item.
- out_pc  out  XLEN  pc of the presented commit.
- out_inst  out  32  instruction of the presented commit.
- out_wdata  out  XLEN  writeback data of the presented commit.
- out_mstatus  out  XLEN  mstatus of the presented commit.
- out_check  out  1  compare enable of the presented commit.
- out_trap_valid  out  1  a trap is presented.
- out_cause  out  XLEN  cause of the presented trap.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset: FIFO empty, lane pointer 0, state IDLE. in_ready=1; out_valid, out_trap_valid and overflow are 0; all data outputs are 0.
  - Reset asserted mid-drain discards all entries immediately.
- Enqueue: accepted when (|in_valid or in_int_xcpt) and in_ready. One entry stores the whole bundle, the hartid, the trap flag and the cause.
  - Cycles with nothing valid are never stored.
- Full boundary:
  - in_ready = !full, registered. It reflects occupancy after this cycle's enqueue and dequeue.
  - An enqueue attempt while full is dropped and sets overflow (sticky until reset).
  - Simultaneous enqueue and dequeue when full is legal and keeps the count at DEPTH.
- Output FSM, states IDLE / LANE / TRAP:
  - IDLE: if the FIFO is non-empty, load the head and go to LANE when any lane is valid, else go to TRAP.
  - LANE:
    - Present the lowest valid lane at or above the lane pointer: out_valid=1 with that lane's fields.
    - On out_ready, advance to the next valid lane.
    - After the last valid lane, go to TRAP if the head trap flag is set. Otherwise pop the entry and go to IDLE, or reload directly if the FIFO is non-empty (no bubble).
  - TRAP: out_trap_valid=1 with out_cause. On out_ready, pop and go to IDLE (or reload, no bubble).
- Handshake and ordering:
  - out_valid and out_trap_valid are mutually exclusive.
  - Presented fields are held stable until out_ready.
  - Within an entry, commits come before the trap.
- Latency: an enqueue into an empty FIFO is presented 1 cycle later (registered head); no combinational path from in_* to out_*.
- Pointers: the log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro COSIM_SERIALIZER_STATS_EN.
- When defined, adds three outputs:
  - stat_commits (64b): counts out_valid&&out_ready.
  - stat_traps (32b): counts out_trap_valid&&out_ready.
  - stat_stall_cycles (64b): counts cycles with !in_ready while an enqueue is requested.
  - All counters reset to 0 and saturate at their maximum.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset value check: hold reset=0, then release -> in_ready=1, out_valid=0, out_trap_valid=0, overflow=0.
- Single bundle: in_valid=2'b11, pc {0x80000004, 0x80000000}, out_ready=1 -> cycle+1 pc 0x80000000, cycle+2 pc 0x80000004, then out_valid=0.
- Sparse bundle plus trap: in_valid=2'b10, pc lane1 0x1000, in_int_xcpt=1, cause 0x8000000000000007 -> commit 0x1000 first, trap cause 0x8000000000000007 next cycle.
- Backpressure: out_ready=0 and 8 full bundles -> in_ready=0 after the 8th. A 9th push sets overflow=1. Releasing out_ready drains 16 commits in order.
- Trap-only entry: in_valid=0, in_int_xcpt=1, cause 0x3 -> one out_trap_valid cycle and zero out_valid cycles.
- Mid-drain reset: assert reset with 3 entries queued -> all outputs 0 at once; after release the FIFO is empty and no stale commits appear.
